uart_tx_scheduler: RTL and testbench
====================================

UART_TX_SCHEDULER -- requirements
Module: uart_tx_scheduler

Interface
REQ-001 SHALL have parameter NUM_REQ, default 4, meaning the number of requesters sharing one UART transmitter (2..8).
REQ-002 SHALL have parameter TIMEOUT_CYCLES, default 1000000, meaning the clk cycles allowed per transmitter phase before abort.
REQ-003 SHALL have port clk, input, 1, system clock; the block uses one clock, all logic on its rising edge.
REQ-004 SHALL have port rst_n, input, 1, reset; asynchronous, active-low.
REQ-005 SHALL have port req_valid, input, NUM_REQ, per-requester word-pending flag.
REQ-006 SHALL have port req_data, input, 32*NUM_REQ, requester i word at bits [32*i+31:32*i].
REQ-007 SHALL have port req_ready, output, NUM_REQ, one-hot, one-cycle accept pulse.
REQ-008 SHALL have port tx_busy, input, 1, transmitter frame-in-progress flag.
REQ-009 SHALL have port tx_start, output, 1, one-cycle launch pulse to transmitter.
REQ-010 SHALL have port tx_data, output, 32, word presented to transmitter; stable from grant until return to IDLE.
REQ-011 SHALL have port grant_id, output, 3, index of the current/last granted requester.
REQ-012 SHALL have port sched_busy, output, 1, high in every state except IDLE.
REQ-013 SHALL have port done, output, 1, one-cycle pulse on frame completion.
REQ-014 SHALL have port timeout_err, output, 1, one-cycle pulse on transmitter-phase timeout.

Function
REQ-015 SHALL implement states IDLE, LAUNCH, WAIT_BUSY, WAIT_DONE.
REQ-016 IDLE: if any req_valid bit high at an edge, SHALL at that edge pick index i by round-robin, set req_ready[i]=1, tx_data=req_data[i], grant_id=i, and go to LAUNCH.
REQ-017 Round-robin SHALL search ascending from (last grant + 1) mod NUM_REQ, wrapping; after reset the search starts at index 0.
REQ-018 Data SHALL be sampled only at the grant edge; req_valid in LAUNCH/WAIT states SHALL be ignored; requester drops valid after seeing req_ready.
REQ-019 LAUNCH: SHALL assert tx_start for exactly one cycle and go to WAIT_BUSY.
REQ-020 WAIT_BUSY: SHALL stay until tx_busy=1, then go to WAIT_DONE.
REQ-021 WAIT_DONE: SHALL stay until tx_busy=0, then pulse done for one cycle and return to IDLE.
REQ-022 Back-to-back: next grant SHALL occur no earlier than the edge after return to IDLE; minimum request-to-request spacing is therefore 4 cycles with a 1-cycle tx_busy.
REQ-023 req_ready, tx_start, done, timeout_err SHALL be registered outputs, each never high for two consecutive cycles.
REQ-024 A requester deasserting valid before grant SHALL lose its turn without side effects; no valid bits SHALL leave state in IDLE and pointer unchanged.

Reset
REQ-025 rst_n low SHALL immediately force IDLE, round-robin pointer to last=NUM_REQ-1, timeout counter 0.
REQ-026 Output reset values SHALL be: req_ready=0, tx_start=0, tx_data=0, grant_id=0, sched_busy=0, done=0, timeout_err=0.
REQ-027 Reset mid-frame SHALL abort without done or timeout_err; transmitter state is not this block's concern.

Configuration
REQ-028 Macro UART_TX_SCHED_TIMEOUT_EN SHALL, when defined, enable a counter cleared on entry to WAIT_BUSY and WAIT_DONE, incremented each cycle in those states.
REQ-029 With the macro, reaching TIMEOUT_CYCLES-1 in either state SHALL pulse timeout_err, suppress done, and return to IDLE; pointer still advances past the granted requester.
REQ-030 Without the macro, no counter SHALL exist, WAIT states wait indefinitely, and timeout_err SHALL be constant 0.

Verification
REQ-031 Reset then req_valid=4'b0100, data 0xDEADBEEF -> req_ready=4'b0100 one cycle, tx_data=0xDEADBEEF, grant_id=2, tx_start pulse next cycle.
REQ-032 All four valid continuously, tx_busy 3 cycles per frame -> grant order 0,1,2,3,0; exactly one done per grant.
REQ-033 Requester 1 valid during WAIT_DONE of requester 3 -> no req_ready until IDLE, then req_ready=4'b0010.
REQ-034 rst_n low during WAIT_DONE -> all outputs at reset values same cycle, no done pulse; next grant with valid=4'b1111 goes to 0.
REQ-035 With UART_TX_SCHED_TIMEOUT_EN, TIMEOUT_CYCLES=16, tx_busy stuck 0 -> timeout_err pulse 16 cycles after WAIT_BUSY entry, return to IDLE, no done.
REQ-036 Without the macro, same stimulus -> FSM remains in WAIT_BUSY indefinitely, timeout_err stays 0.

Source files
------------

// File: rtl/uart_tx_scheduler.sv
// Round-robin scheduler that shares one UART transmitter among NUM_REQ requesters.
// Optional transmitter-phase timeout is enabled by defining UART_TX_SCHED_TIMEOUT_EN.
module uart_tx_scheduler #(
    parameter int NUM_REQ        = 4,
    parameter int TIMEOUT_CYCLES = 1000000
) (
    input  logic                   clk,
    input  logic                   rst_n,
    input  logic [NUM_REQ-1:0]     req_valid,
    input  logic [32*NUM_REQ-1:0]  req_data,
    output logic [NUM_REQ-1:0]     req_ready,
    input  logic                   tx_busy,
    output logic                   tx_start,
    output logic [31:0]            tx_data,
    output logic [2:0]             grant_id,
    output logic                   sched_busy,
    output logic                   done,
    output logic                   timeout_err
);

    typedef enum logic [1:0] {
        S_IDLE      = 2'd0,
        S_LAUNCH    = 2'd1,
        S_WAIT_BUSY = 2'd2,
        S_WAIT_DONE = 2'd3
    } state_t;

    state_t               r_state;
    logic [2:0]           r_last;
    logic [NUM_REQ-1:0]   r_req_ready;
    logic                 r_tx_start;
    logic [31:0]          r_tx_data;
    logic [2:0]           r_grant_id;
    logic                 r_sched_busy;
    logic                 r_done;
    logic                 r_timeout_err;

`ifdef UART_TX_SCHED_TIMEOUT_EN
    localparam int CNT_W = (TIMEOUT_CYCLES > 1) ? $clog2(TIMEOUT_CYCLES) : 1;
    localparam logic [CNT_W-1:0] TMO_LAST = CNT_W'(TIMEOUT_CYCLES - 1);
    logic [CNT_W-1:0]     r_tmo_cnt;
`endif

    logic [7:0]           w_valid8;
    logic [3:0]           w_pos;
    logic                 w_found;
    logic [2:0]           w_idx;
    logic [NUM_REQ-1:0]   w_onehot;
    logic [31:0]          w_sel_data;

    // Round-robin pick: first valid index at or after last grant + 1, wrapping.
    always_comb begin
        w_valid8               = 8'd0;
        w_valid8[NUM_REQ-1:0]  = req_valid;
        w_found                = 1'b0;
        w_idx                  = 3'd0;
        w_pos                  = 4'd0;
        for (int k = 0; k < NUM_REQ; k++) begin
            w_pos = {1'b0, r_last} + 4'd1 + 4'(k);
            if (w_pos >= 4'(NUM_REQ)) begin
                w_pos = w_pos - 4'(NUM_REQ);
            end else begin
                w_pos = w_pos;
            end
            if (!w_found && w_valid8[w_pos[2:0]]) begin
                w_found = 1'b1;
                w_idx   = w_pos[2:0];
            end else begin
                w_found = w_found;
            end
        end
        w_onehot   = '0;
        w_sel_data = 32'd0;
        for (int i = 0; i < NUM_REQ; i++) begin
            if (3'(i) == w_idx) begin
                w_onehot[i] = 1'b1;
                w_sel_data  = req_data[32*i +: 32];
            end else begin
                w_onehot[i] = 1'b0;
            end
        end
    end

    // Scheduler FSM; all outputs are registered and pulses self-clear each cycle.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_state       <= S_IDLE;
            r_last        <= 3'(NUM_REQ - 1);
            r_req_ready   <= '0;
            r_tx_start    <= 1'b0;
            r_tx_data     <= 32'd0;
            r_grant_id    <= 3'd0;
            r_sched_busy  <= 1'b0;
            r_done        <= 1'b0;
            r_timeout_err <= 1'b0;
`ifdef UART_TX_SCHED_TIMEOUT_EN
            r_tmo_cnt     <= '0;
`endif
        end else begin
            r_req_ready   <= '0;
            r_tx_start    <= 1'b0;
            r_done        <= 1'b0;
            r_timeout_err <= 1'b0;
            case (r_state)
                S_IDLE: begin
                    if (w_found) begin
                        r_req_ready  <= w_onehot;
                        r_tx_data    <= w_sel_data;
                        r_grant_id   <= w_idx;
                        r_last       <= w_idx;
                        r_sched_busy <= 1'b1;
                        r_state      <= S_LAUNCH;
                    end
                end
                S_LAUNCH: begin
                    r_tx_start <= 1'b1;
                    r_state    <= S_WAIT_BUSY;
`ifdef UART_TX_SCHED_TIMEOUT_EN
                    r_tmo_cnt  <= '0;
`endif
                end
                S_WAIT_BUSY: begin
                    if (tx_busy) begin
                        r_state   <= S_WAIT_DONE;
`ifdef UART_TX_SCHED_TIMEOUT_EN
                        r_tmo_cnt <= '0;
                    end else if (r_tmo_cnt == TMO_LAST) begin
                        r_timeout_err <= 1'b1;
                        r_sched_busy  <= 1'b0;
                        r_state       <= S_IDLE;
                    end else begin
                        r_tmo_cnt <= r_tmo_cnt + 1'b1;
`endif
                    end
                end
                S_WAIT_DONE: begin
                    if (!tx_busy) begin
                        r_done       <= 1'b1;
                        r_sched_busy <= 1'b0;
                        r_state      <= S_IDLE;
`ifdef UART_TX_SCHED_TIMEOUT_EN
                    end else if (r_tmo_cnt == TMO_LAST) begin
                        r_timeout_err <= 1'b1;
                        r_sched_busy  <= 1'b0;
                        r_state       <= S_IDLE;
                    end else begin
                        r_tmo_cnt <= r_tmo_cnt + 1'b1;
`endif
                    end
                end
                default: begin
                    r_sched_busy <= 1'b0;
                    r_state      <= S_IDLE;
                end
            endcase
        end
    end

    assign req_ready   = r_req_ready;
    assign tx_start    = r_tx_start;
    assign tx_data     = r_tx_data;
    assign grant_id    = r_grant_id;
    assign sched_busy  = r_sched_busy;
    assign done        = r_done;
    assign timeout_err = r_timeout_err;

endmodule

// File: tb/tb_uart_tx_scheduler.sv
// Randomized bench for uart_tx_scheduler against a transaction-level round-robin model.
module tb_uart_tx_scheduler;

    localparam int N   = 4;
    localparam int TMO = 16;

    logic              clk = 1'b0;
    logic              rst_n;
    logic [N-1:0]      req_valid;
    logic [32*N-1:0]   req_data;
    logic [N-1:0]      req_ready;
    logic              tx_busy;
    logic              tx_start;
    logic [31:0]       tx_data;
    logic [2:0]        grant_id;
    logic              sched_busy;
    logic              done;
    logic              timeout_err;

    int checks   = 0;
    int failures = 0;
    int last_g;

    uart_tx_scheduler #(.NUM_REQ(N), .TIMEOUT_CYCLES(TMO)) dut (
        .clk(clk), .rst_n(rst_n), .req_valid(req_valid), .req_data(req_data),
        .req_ready(req_ready), .tx_busy(tx_busy), .tx_start(tx_start),
        .tx_data(tx_data), .grant_id(grant_id), .sched_busy(sched_busy),
        .done(done), .timeout_err(timeout_err)
    );

    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [63:0] got, input logic [63:0] exp);
        checks++;
        if (got !== exp) begin
            failures++;
            $display("FAIL %s got=%0h exp=%0h", tag, got, exp);
        end
    endtask

    // Reference arbitration: ascending search starting after the last grant.
    function automatic int rr_pick(input logic [N-1:0] pat, input int last);
        for (int k = 1; k <= N; k++) begin
            int idx;
            idx = (last + k) % N;
            if (pat[idx]) return idx;
        end
        return -1;
    endfunction

    function automatic logic [N-1:0] onehot(input int g);
        logic [N-1:0] v;
        v = '0;
        v[g] = 1'b1;
        return v;
    endfunction

    task automatic check_reset_outputs(input string tag);
        chk({tag, "_ready"}, req_ready, 0);
        chk({tag, "_start"}, tx_start, 0);
        chk({tag, "_data"}, tx_data, 0);
        chk({tag, "_gid"}, grant_id, 0);
        chk({tag, "_busy"}, sched_busy, 0);
        chk({tag, "_done"}, done, 0);
        chk({tag, "_tmo"}, timeout_err, 0);
    endtask

    // Applies pat at a negedge with the DUT idle; returns granted index or -1.
    task automatic grant_phase(input logic [N-1:0] pat, input bit rand_data, output int g,
                               output logic [31:0] exp_data);
        if (rand_data) begin
            for (int i = 0; i < N; i++) req_data[32*i +: 32] = $urandom;
        end
        req_valid = pat;
        g = rr_pick(pat, last_g);
        exp_data = 32'd0;
        @(negedge clk);
        chk("done_once", done, 0);
        if (g < 0) begin
            chk("idle_ready", req_ready, 0);
            chk("idle_busy", sched_busy, 0);
        end else begin
            exp_data = req_data[32*g +: 32];
            chk("grant_ready", req_ready, onehot(g));
            chk("grant_data", tx_data, exp_data);
            chk("grant_id", grant_id, g);
            chk("grant_busy", sched_busy, 1);
            chk("grant_nostart", tx_start, 0);
            last_g = g;
            req_valid = N'($urandom) & ~onehot(g);
            for (int i = 0; i < N; i++) req_data[32*i +: 32] = $urandom;
            @(negedge clk);
            chk("launch_start", tx_start, 1);
            chk("launch_ready", req_ready, 0);
            chk("launch_data", tx_data, exp_data);
        end
    endtask

    task automatic run_frame(input logic [N-1:0] pat, input int d, input int b, input bit rand_data);
        int g;
        logic [31:0] exp_data;
        grant_phase(pat, rand_data, g, exp_data);
        if (g >= 0) begin
            repeat (d) begin
                req_valid = N'($urandom);
                @(negedge clk);
                chk("wb_start", tx_start, 0);
                chk("wb_done", done, 0);
                chk("wb_ready", req_ready, 0);
                chk("wb_busy", sched_busy, 1);
            end
            tx_busy = 1'b1;
            repeat (b) begin
                req_valid = N'($urandom);
                @(negedge clk);
                chk("wd_done", done, 0);
                chk("wd_ready", req_ready, 0);
                chk("wd_data", tx_data, exp_data);
                chk("wd_tmo", timeout_err, 0);
            end
            tx_busy = 1'b0;
            @(negedge clk);
            chk("frame_done", done, 1);
            chk("frame_idle", sched_busy, 0);
            chk("frame_tmo", timeout_err, 0);
            chk("frame_ready", req_ready, 0);
        end
    endtask

    initial begin
        int g;
        logic [31:0] exp_data;
        rst_n     = 1'b0;
        req_valid = '0;
        req_data  = '0;
        tx_busy   = 1'b0;
        last_g    = N - 1;
        repeat (2) @(negedge clk);
        check_reset_outputs("rst");
        rst_n = 1'b1;
        @(negedge clk);
        chk("post_rst_idle", sched_busy, 0);

        req_data[32*2 +: 32] = 32'hDEADBEEF;
        run_frame(4'b0100, 1, 1, 1'b0);

        repeat (5) run_frame(4'b1111, 0, 3, 1'b1);

        for (int n = 0; n < 60; n++) begin
            run_frame(N'($urandom), int'($urandom_range(0, 3)), int'($urandom_range(1, 4)), 1'b1);
        end

        // Transmitter never reports busy.
        grant_phase(4'b1011, 1'b1, g, exp_data);
        req_valid = '0;
`ifdef UART_TX_SCHED_TIMEOUT_EN
        repeat (TMO - 1) begin
            @(negedge clk);
            chk("tmo_wait", timeout_err, 0);
            chk("tmo_wait_busy", sched_busy, 1);
        end
        @(negedge clk);
        chk("tmo_pulse", timeout_err, 1);
        chk("tmo_nodone", done, 0);
        chk("tmo_idle", sched_busy, 0);
        @(negedge clk);
        chk("tmo_single", timeout_err, 0);
`else
        repeat (40) begin
            @(negedge clk);
            chk("stuck_tmo", timeout_err, 0);
            chk("stuck_busy", sched_busy, 1);
            chk("stuck_done", done, 0);
        end
        tx_busy = 1'b1;
        @(negedge clk);
        tx_busy = 1'b0;
        @(negedge clk);
        chk("stuck_release_done", done, 1);
`endif

        // Reset while waiting for the frame to end.
        run_frame(4'b0110, 0, 2, 1'b1);
        grant_phase(4'b1111, 1'b1, g, exp_data);
        tx_busy = 1'b1;
        repeat (2) @(negedge clk);
        rst_n = 1'b0;
        #1;
        check_reset_outputs("midrst");
        last_g  = N - 1;
        tx_busy = 1'b0;
        @(negedge clk);
        chk("midrst_nodone", done, 0);
        rst_n = 1'b1;
        run_frame(4'b1111, 1, 1, 1'b1);
        chk("midrst_regrant", grant_id, 0);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
